// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/grant/response, decode
// valid/ready handoff and the execute-stage redirect.
interface fetch_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [31:0]      imem_rdata;
  logic             if_valid;
  logic             if_ready;
  logic [31:0]      if_instr;
  logic [WIDTH-1:0] if_pc;
  logic [WIDTH-1:0] if_pc_plus4;
  logic             pc_src;
  logic [WIDTH-1:0] jump_target_addr;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready, pc_src, jump_target_addr
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready, pc_src, jump_target_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one memory request in
// flight and hands fetched words to decode; a redirect flushes held/in-flight data.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input logic    clk,
  input logic    rst_n,
  fetch_if.master bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_DROP = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'b100};
  localparam logic [31:0]      NOP     = 32'h0000_0013;

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_pc;
  logic             r_imem_req;
  logic             r_if_valid;
  logic [31:0]      r_if_instr;
  logic [WIDTH-1:0] r_if_pc;
  logic [WIDTH-1:0] r_if_pc_plus4;

  logic [2:0]       w_state_nxt;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_target;
  logic             w_capture;

  assign w_target = {bus.jump_target_addr[WIDTH-1:2], 2'b00};

  // Next-state and next-PC selection; redirect always wins over normal progress.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (bus.pc_src) begin
          w_pc_nxt    = w_target;
          w_state_nxt = bus.imem_gnt ? S_DROP : S_REQ;
        end else if (bus.imem_gnt) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (bus.pc_src) begin
          w_pc_nxt    = w_target;
          w_state_nxt = bus.imem_rvalid ? S_REQ : S_DROP;
        end else if (bus.imem_rvalid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_DROP: begin
        if (bus.pc_src) begin
          w_pc_nxt = w_target;
        end else begin
          w_pc_nxt = r_pc;
        end
        w_state_nxt = bus.imem_rvalid ? S_REQ : S_DROP;
      end
      S_HOLD: begin
        if (bus.pc_src) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_REQ;
        end else if (bus.if_ready) begin
          w_pc_nxt    = r_pc + PC_STEP;
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, PC and output flags; flags are pre-decoded from next state so they stay pure registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_imem_req <= 1'b0;
      r_if_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_imem_req <= (w_state_nxt == S_REQ);
      r_if_valid <= (w_state_nxt == S_HOLD);
    end
  end

  // Held instruction and its PC, written only when a live response is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_instr    <= NOP;
      r_if_pc       <= RESET_PC;
      r_if_pc_plus4 <= RESET_PC + PC_STEP;
    end else if (w_capture) begin
      r_if_instr    <= bus.imem_rdata;
      r_if_pc       <= r_pc;
      r_if_pc_plus4 <= r_pc + PC_STEP;
    end else begin
      r_if_instr    <= r_if_instr;
      r_if_pc       <= r_if_pc;
      r_if_pc_plus4 <= r_if_pc_plus4;
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_pc;
  assign bus.if_valid    = r_if_valid;
  assign bus.if_instr    = r_if_instr;
  assign bus.if_pc       = r_if_pc;
  assign bus.if_pc_plus4 = r_if_pc_plus4;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: drives memory, decode and redirect by hand
// and checks outputs on the falling edge against hand-computed values.
module tb_fetch_unit;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  fetch_if #(.WIDTH(32)) bus ();

  fetch_unit #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hA500_0000 ^ a;
  endfunction

  // Precondition: in REQ at a negedge. Grants, returns data next cycle, leaves DUT in HOLD.
  task automatic do_fetch(input logic [31:0] a);
    chk("req_high", {31'd0, bus.imem_req}, 32'd1);
    chk("req_addr", bus.imem_addr, a);
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    chk("wait_req_low", {31'd0, bus.imem_req}, 32'd0);
    chk("wait_valid_low", {31'd0, bus.if_valid}, 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = word_at(a);
    step();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    chk("hold_valid", {31'd0, bus.if_valid}, 32'd1);
    chk("hold_instr", bus.if_instr, word_at(a));
    chk("hold_pc", bus.if_pc, a);
    chk("hold_pc4", bus.if_pc_plus4, a + 32'd4);
  endtask

  task automatic accept();
    bus.if_ready = 1'b1;
    step();
    bus.if_ready = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0000_0000;
    bus.if_ready = 1'b0;
    bus.pc_src = 1'b0;
    bus.jump_target_addr = 32'h0000_0000;
    step();
    step();
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0000_0000);
    chk("rst_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("rst_instr", bus.if_instr, 32'h0000_0013);
    chk("rst_pc", bus.if_pc, 32'h0000_0000);
    chk("rst_pc4", bus.if_pc_plus4, 32'h0000_0004);

    // Release: IDLE for one edge, then REQ.
    rst_n = 1'b1;
    step();
    do_fetch(32'h0000_0000);
    accept();
    do_fetch(32'h0000_0004);
    accept();
    do_fetch(32'h0000_0008);

    // Backpressure for five cycles.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", {31'd0, bus.if_valid}, 32'd1);
      chk("bp_req", {31'd0, bus.imem_req}, 32'd0);
      chk("bp_instr", bus.if_instr, word_at(32'h0000_0008));
      chk("bp_pc", bus.if_pc, 32'h0000_0008);
    end
    accept();
    chk("bp_next_addr", bus.imem_addr, 32'h0000_000C);
    chk("bp_valid_drop", {31'd0, bus.if_valid}, 32'd0);

    // Redirect in HOLD beats if_ready.
    do_fetch(32'h0000_000C);
    bus.if_ready = 1'b1;
    bus.pc_src = 1'b1;
    bus.jump_target_addr = 32'h0000_0100;
    step();
    bus.if_ready = 1'b0;
    bus.pc_src = 1'b0;
    chk("hold_redir_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("hold_redir_addr", bus.imem_addr, 32'h0000_0100);

    // Redirect in WAIT without response: DROP, stale response discarded.
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    bus.pc_src = 1'b1;
    bus.jump_target_addr = 32'h0000_0200;
    step();
    bus.pc_src = 1'b0;
    chk("drop_req", {31'd0, bus.imem_req}, 32'd0);
    step();
    chk("drop_wait_req", {31'd0, bus.imem_req}, 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata = 32'hBAD0_0100;
    step();
    bus.imem_rvalid = 1'b0;
    chk("drop_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("drop_instr_kept", bus.if_instr, word_at(32'h0000_000C));
    do_fetch(32'h0000_0200);
    accept();

    // Ungranted REQ for three cycles, then retarget to a misaligned address.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ungnt_req", {31'd0, bus.imem_req}, 32'd1);
      chk("ungnt_addr", bus.imem_addr, 32'h0000_0204);
    end
    bus.pc_src = 1'b1;
    bus.jump_target_addr = 32'h0000_0303;
    step();
    chk("ungnt_redir_addr", bus.imem_addr, 32'h0000_0300);
    bus.jump_target_addr = 32'hFFFF_FFFF;
    step();
    bus.pc_src = 1'b0;
    do_fetch(32'hFFFF_FFFC);
    accept();
    chk("wrap_addr", bus.imem_addr, 32'h0000_0000);

    // Asynchronous reset during WAIT.
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("arst_addr", bus.imem_addr, 32'h0000_0000);
    chk("arst_valid", {31'd0, bus.if_valid}, 32'd0);
    chk("arst_instr", bus.if_instr, 32'h0000_0013);
    chk("arst_pc", bus.if_pc, 32'h0000_0000);
    chk("arst_pc4", bus.if_pc_plus4, 32'h0000_0004);
    step();
    rst_n = 1'b1;
    step();
    do_fetch(32'h0000_0000);
    accept();

    // Redirect coinciding with grant in REQ, then redirect coinciding with stale response in DROP.
    bus.imem_gnt = 1'b1;
    bus.pc_src = 1'b1;
    bus.jump_target_addr = 32'h0000_0400;
    step();
    bus.imem_gnt = 1'b0;
    chk("req_gnt_redir_req", {31'd0, bus.imem_req}, 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.jump_target_addr = 32'h0000_0500;
    step();
    bus.imem_rvalid = 1'b0;
    bus.pc_src = 1'b0;
    chk("drop_both_req", {31'd0, bus.imem_req}, 32'd1);
    chk("drop_both_addr", bus.imem_addr, 32'h0000_0500);
    chk("drop_both_valid", {31'd0, bus.if_valid}, 32'd0);
    do_fetch(32'h0000_0500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the core: the consumer of the redirect (`pc_src`, `jump_target_addr`) that the execute stage produces. It owns the program counter and issues one instruction-memory request at a time over a request/grant/response handshake. It presents each fetched instruction to decode with a valid/ready handshake. A redirect flushes any held or in-flight instruction.

## Interface
- `WIDTH`, 32, address/PC width.
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  WIDTH  fetch address; equals current PC.
- `imem_gnt`  in  1  request accepted this cycle when `imem_req`=1.
- `imem_rvalid`  in  1  response valid; earliest one cycle after grant.
- `imem_rdata`  in  32  instruction word, valid with `imem_rvalid`.
- `if_valid`  out  1  instruction available to decode.
- `if_ready`  in  1  decode accepts instruction when `if_valid`=1.
- `if_instr`  out  32  held instruction.
- `if_pc`  out  WIDTH  PC of held instruction.
- `if_pc_plus4`  out  WIDTH  `if_pc`+4, modulo 2^WIDTH.
- `pc_src`  in  1  redirect strobe from execute.
- `jump_target_addr`  in  WIDTH  redirect target.

## Operation
- States: IDLE, REQ, WAIT, DROP, HOLD. At most one outstanding memory request.
- Redirect target load: `pc <= {jump_target_addr[WIDTH-1:2], 2'b00}`. PC arithmetic wraps modulo 2^WIDTH.
- IDLE: entered only by reset. `imem_req`=0. Goes to REQ on the first clock edge after `rst_n` rises.
- REQ: `imem_req`=1, `imem_addr`=pc.
  - `pc_src`=1 and `imem_gnt`=1: load target, go to DROP. The granted request carried the stale address.
  - `pc_src`=1 and `imem_gnt`=0: load target, stay in REQ. The address may change while ungranted.
  - `imem_gnt`=1 only: go to WAIT.
- WAIT: `imem_req`=0.
  - `pc_src`=1 and `imem_rvalid`=1: discard data, load target, go to REQ.
  - `pc_src`=1 and `imem_rvalid`=0: load target, go to DROP.
  - `imem_rvalid`=1 only: capture `if_instr`←`imem_rdata` and `if_pc`←pc, go to HOLD.
- DROP: `imem_req`=0. Waits for the stale response.
  - `imem_rvalid`=1: discard it, go to REQ.
  - `pc_src`=1 in DROP: load target, stay in DROP. When both occur in the same cycle, the response is discarded, the target is loaded and the state goes to REQ.
- HOLD: `if_valid`=1.
  - `pc_src`=1: load target, drop `if_valid`, go to REQ. Priority over `if_ready`.
  - `if_ready`=1: `pc <= pc+4`, go to REQ.
  - Otherwise hold all outputs stable.
- `if_valid` is 1 only in HOLD. `if_instr`/`if_pc` change only on capture.
- A `pc_src` pulse while `if_valid`=1 guarantees that instruction is never accepted.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - state IDLE; pc=`RESET_PC`.
  - `imem_req`=0; `imem_addr`=`RESET_PC`.
  - `if_valid`=0; `if_instr`=32'h0000_0013 (NOP).
  - `if_pc`=`RESET_PC`; `if_pc_plus4`=`RESET_PC`+4.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately. Responses after release are only relevant after the new request; the memory side is reset by the same `rst_n`.
- `imem_req`, `imem_addr` and `if_valid` are registered-state decodes: no combinational path from `pc_src`, `imem_gnt` or `if_ready`.
- Best-case throughput, with single-cycle grant and next-cycle `imem_rvalid`: one instruction per 3 cycles (REQ→WAIT→HOLD).
- Redirect penalty: target is requested in the cycle after `pc_src` (REQ), or after the stale response drains (DROP).

## Test plan
- Reset release, memory grants immediately and returns `rdata` one cycle later, `if_ready`=1 → `imem_addr` 0x0, 0x4, 0x8 on successive requests. `if_valid` pulses with `if_pc` 0x0/0x4/0x8 and matching `if_pc_plus4`.
- Backpressure: `if_ready`=0 for 5 cycles in HOLD → `if_instr`/`if_pc` stable and no `imem_req`. Next request is at pc+4 only after `if_ready`=1.
- Redirect in HOLD with `if_ready`=1 and `pc_src`=1, target 0x100 → instruction not accepted, next `imem_addr`=0x100.
- Redirect in WAIT without `rvalid`, target 0x200 → stale response discarded (`if_valid` stays 0), then request at 0x200 and its data delivered.
- Ungranted REQ: `imem_gnt`=0 for 3 cycles, `pc_src` with 0x303 → `imem_addr` becomes 0x300. `pc`=0xFFFF_FFFC followed by accept → next address 0x0.
- `rst_n` pulsed low during WAIT → outputs immediately at reset values, fetch restarts at `RESET_PC`.
